uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO.
// Frames go out LSB first, back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int CW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     cnt_q;

    logic            full;
    logic            empty;
    logic            wr_en;
    logic            pop;
    logic            baud_last;

    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign wr_en     = tx_valid && !full;
    assign baud_last = (baud_q == BAUD_LAST);

    assign tx_ready  = !full;
    assign tx_busy   = !empty || (state_q != IDLE);
    assign fifo_cnt  = cnt_q;
    assign uart_txd  = txd_q;

    // FIFO storage; stale entries are harmless because occupancy gates reads
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Transmitter state, counters, shift register and line register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // Next-state logic; a pop happens from IDLE or at the last STOP cycle
    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the next cycle, registered so the pin is glitch-free
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a short baud period (8 clocks per bit).
// A line decoder checks every frame's timing and byte order.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 80;
    localparam int UART_BPS = 10;
    localparam int B        = 8;
    localparam int DEPTH    = 16;
    localparam int CNTW     = $clog2(DEPTH) + 1;

    logic            sys_clk  = 1'b0;
    logic            sys_rst  = 1'b1;
    logic [7:0]      tx_data  = 8'h00;
    logic            tx_valid = 1'b0;
    logic            tx_ready;
    logic            uart_txd;
    logic            tx_busy;
    logic [CNTW-1:0] fifo_cnt;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .UART_BPS   (UART_BPS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .fifo_cnt (fifo_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    logic [7:0]  exp_q[$];
    int unsigned starts[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Line decoder: every bit must hold exactly B cycles
    initial begin : mon
        logic [7:0] byte_v;
        int         bad;
        bit         abort;
        logic       lvl;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && uart_txd === 1'b0) begin
                starts.push_back(cyc);
                bad    = 0;
                abort  = 0;
                byte_v = 8'h00;
                lvl    = 1'b0;
                for (int b = 0; b < 10 && !abort; b++) begin
                    for (int c = 0; c < B && !abort; c++) begin
                        if (b != 0 || c != 0) @(negedge sys_clk);
                        if (sys_rst) begin
                            abort = 1;
                        end else if (c == 0) begin
                            lvl = uart_txd;
                            if (b >= 1 && b <= 8) byte_v[b-1] = lvl;
                            if (b == 9 && lvl !== 1'b1) bad++;
                        end else if (uart_txd !== lvl) begin
                            bad++;
                        end
                    end
                end
                if (!abort) begin
                    check("frame_shape", bad, 0);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got 0x%0h, want none",
                                 byte_v);
                    end else begin
                        check("frame_byte", int'(byte_v), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, "_timeout"}, int'(n >= limit), 0);
        check({name, "_cnt0"}, int'(fifo_cnt), 0);
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        check("push_ready_timeout", int'(n >= 2000), 0);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        int         cnt;
        logic       rdy;
        logic       txd;
        logic       busy;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bad;
        int n;
        int sizes[6];
        int k;

        vecs[0] = '{1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h55, 1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge sys_clk);
        check("rst_txd", int'(uart_txd), 1);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_cnt", int'(fifo_cnt), 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Single byte 0x55: latency table, then end-of-frame boundary
        exp_q.push_back(8'h55);
        foreach (vecs[i]) begin
            tx_valid = vecs[i].v;
            tx_data  = vecs[i].d;
            @(negedge sys_clk);
            tx_valid = 1'b0;
            check($sformatf("vec%0d_cnt", i), int'(fifo_cnt), vecs[i].cnt);
            check($sformatf("vec%0d_ready", i), int'(tx_ready), int'(vecs[i].rdy));
            check($sformatf("vec%0d_txd", i), int'(uart_txd), int'(vecs[i].txd));
            check($sformatf("vec%0d_busy", i), int'(tx_busy), int'(vecs[i].busy));
        end
        repeat (10*B - 3) @(negedge sys_clk);
        check("single_stop_busy", int'(tx_busy), 1);
        check("single_stop_txd", int'(uart_txd), 1);
        @(negedge sys_clk);
        check("single_idle_busy", int'(tx_busy), 0);
        check("single_idle_txd", int'(uart_txd), 1);
        drain("single", 100);

        // Burst of 17 fills the FIFO; an 18th push is dropped
        repeat (5) @(negedge sys_clk);
        starts.delete();
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 17; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'(i);
            @(negedge sys_clk);
        end
        tx_valid = 1'b0;
        check("burst_full_cnt", int'(fifo_cnt), 16);
        check("burst_full_ready", int'(tx_ready), 0);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        check("burst_drop_cnt", int'(fifo_cnt), 16);
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("burst_ready_rise", int'(tx_ready), 1);
        check("burst_after_pop_cnt", int'(fifo_cnt), 15);
        drain("burst", 17*10*B + 100);
        check("burst_frames", starts.size(), 17);
        bad = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != 10*B) bad++;
        end
        check("burst_gap", bad, 0);

        // Push lands on the last STOP cycle while three bytes are queued
        repeat (5) @(negedge sys_clk);
        starts.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'h5A);
        tx_valid = 1'b1;
        tx_data  = 8'h3C; @(negedge sys_clk);
        tx_data  = 8'hC3; @(negedge sys_clk);
        tx_data  = 8'h81; @(negedge sys_clk);
        tx_data  = 8'h7E; @(negedge sys_clk);
        tx_valid = 1'b0;
        repeat (10*B - 3) @(negedge sys_clk);
        check("simul_pre_cnt", int'(fifo_cnt), 3);
        check("simul_pre_txd", int'(uart_txd), 1);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        check("simul_cnt", int'(fifo_cnt), 3);
        check("simul_next_start", int'(uart_txd), 0);
        drain("simul", 6*10*B + 100);
        bad = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != 10*B) bad++;
        end
        check("simul_frames", starts.size(), 5);
        check("simul_gap", bad, 0);

        // Pointer wrap: 40 distinct bytes in mixed bursts
        sizes = '{7, 3, 12, 5, 9, 4};
        k = 0;
        for (int s = 0; s < 6; s++) begin
            for (int j = 0; j < sizes[s]; j++) begin
                exp_q.push_back(8'(k*7 + 8'h11));
                push(8'(k*7 + 8'h11));
                k++;
            end
            repeat (20 + 13*s) @(negedge sys_clk);
        end
        drain("wrap", 40*10*B + 200);

        // Reset during DATA bit 3 of 0xE0 with five bytes queued
        repeat (5) @(negedge sys_clk);
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'hE0 + 8'(i);
            @(negedge sys_clk);
        end
        tx_valid = 1'b0;
        repeat (32) @(negedge sys_clk);
        check("rst_mid_pre_cnt", int'(fifo_cnt), 5);
        check("rst_mid_pre_txd", int'(uart_txd), 0);
        #2 sys_rst = 1'b1;
        #1;
        check("rst_mid_txd", int'(uart_txd), 1);
        check("rst_mid_cnt", int'(fifo_cnt), 0);
        check("rst_mid_busy", int'(tx_busy), 0);
        repeat (2) @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30*B; i++) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("rst_mid_idle", bad, 0);

        // Fresh byte after reset must frame cleanly
        exp_q.push_back(8'hA3);
        push(8'hA3);
        drain("post_rst", 10*B + 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
